keypad_scan: RTL
================

// Module: keypad_scan
// PURPOSE
//  Input-side counterpart of the multiplexed 7-seg display driver. Scans a 4x4 matrix keypad
//  by driving one column low at a time and reading the rows. Debounces each press over whole
//  scan frames. Delivers each accepted key as a 4-bit code through a valid/ready handshake to
//  the MIPS CPU I/O path. Sits beside the display driver in the board top level, on the system clk.
// PARAMETERS
//  SCAN_DIV        10_000  clk cycles per column slot (frame = 4*SCAN_DIV cycles); >=2
//  DEBOUNCE_SCANS  4       consecutive identical frames needed to accept press/release; >=1
// PORTS
//  clk          in   1  system clock
//  clr          in   1  reset, asynchronous, active-high
//  row          in   4  keypad rows, active-low (board pull-ups), asynchronous to clk
//  col          out  4  keypad column drive, active-low one-hot
//  key_code     out  4  {row_idx[1:0], col_idx[1:0]} of the accepted key
//  key_valid    out  1  key_code holds an unconsumed key
//  key_ready    in   1  consumer accepts key; a transfer occurs on a clk edge with valid&ready
//  key_pressed  out  1  debounced level: an accepted key is currently held
//  overrun      out  1  sticky: a press was dropped because key_valid was still set
//  ovr_clr      in   1  synchronous clear of overrun
// BEHAVIOUR
//  Reset (clr=1, any time, mid-frame included): col=4'b1110, slot counter=0, col_idx=0,
//   frame accumulator cleared, FSM=RELEASED, debounce count=0, key_code=0, key_valid=0,
//   key_pressed=0, overrun=0. All outputs are registered.
//  Synchroniser: row passes through 2 flops before use.
//  Scan: slot counter counts 0..SCAN_DIV-1. At count SCAN_DIV-1, the synchronised rows are
//   sampled for col_idx. Then the counter wraps to 0, col_idx increments mod 4, and col rotates
//   1110->1101->1011->0111->1110.
//  Frame result: evaluated at the col_idx=3 sample edge over the 16 sampled bits.
//   Exactly one low bit gives SINGLE(code). Zero low bits gives NONE. Two or more gives MULTI.
//   MULTI is treated as "not the candidate" everywhere.
//  Debounce FSM (advances only on frame-result edges; cand = 4-bit candidate, cnt = count):
//   RELEASED:     SINGLE(k) -> cand=k, cnt=1. If DEBOUNCE_SCANS=1, go to PRESSED with a press
//                 event; otherwise go to PRESS_PEND. NONE/MULTI -> stay.
//   PRESS_PEND:   SINGLE(cand) -> cnt+1. When cnt+1 = DEBOUNCE_SCANS, go to PRESSED with a press
//                 event. Any other result -> RELEASED, cnt=0.
//   PRESSED:      SINGLE(cand) -> stay. Other result -> cnt=1. If DEBOUNCE_SCANS=1, go to
//                 RELEASED; otherwise go to RELEASE_PEND.
//   RELEASE_PEND: result != SINGLE(cand) -> cnt+1. When cnt+1 = DEBOUNCE_SCANS, go to RELEASED.
//                 SINGLE(cand) -> PRESSED, cnt=0.
//   key_pressed=1 exactly while in PRESSED or RELEASE_PEND.
//  Output register, evaluated per edge:
//   press event, key_valid=0 or transfer this edge -> key_code=cand, key_valid=1.
//   press event, key_valid=1 and no transfer -> overrun=1; key_code/key_valid unchanged (new key dropped).
//   transfer with no press event -> key_valid=0, key_code held.
//   ovr_clr and a new overrun on the same edge -> overrun=1 (set wins).
//  Latency: key_valid rises on the clk edge of the DEBOUNCE_SCANS-th qualifying frame result.
//   key_valid never drops without a transfer or reset.
//   key_ready is don't-care while key_valid=0.
// TESTING (SCAN_DIV=4, DEBOUNCE_SCANS=3; row model pulls row r low when col drives its column low)
//  1 Free-run, no key -> col steps 1110,1101,1011,0111 every 4 clks, repeating.
//    Assert clr mid-slot -> col=1110 and all outputs 0 immediately (asynchronous).
//  2 Hold row2/col1 for 5 frames, key_ready=0 -> key_valid=1 at the 3rd frame-result edge,
//    key_code=4'h9, key_pressed=1. Pulse key_ready for 1 clk -> key_valid=0, no re-fire while held.
//  3 Bounce: key 4'h9 present 2 frames, absent 1 frame, then present 3 frames -> no event until
//    the end of the last 3; exactly one key_valid rise.
//  4 Hold row0/col0 and row3/col3 together for 6 frames -> key_valid stays 0, key_pressed stays 0.
//  5 Accept 4'h3 (leave key_ready=0), release 3 frames, press 4'hC for 3 frames -> overrun=1,
//    key_code stays 4'h3. Pulse ovr_clr -> overrun=0.
//  6 key_valid=1 (4'h3); hold key_ready=1 so the transfer coincides with the 4'hC press edge ->
//    key_valid stays 1, key_code=4'hC, overrun=0.

Source files
------------

// File: rtl/keypad_scan.sv
// keypad_scan
//   Scans a 4x4 active-low matrix keypad one column at a time and debounces
//   over whole scan frames. Each accepted key is offered as a 4-bit code
//   through a valid/ready handshake.
//
//   Ports
//     clk         system clock
//     clr         asynchronous active-high reset
//     row[3:0]    keypad rows, active-low, asynchronous to clk
//     col[3:0]    column drive, active-low one-hot
//     key_code    {row_idx, col_idx} of the accepted key
//     key_valid   key_code holds an unconsumed key
//     key_ready   consumer accepts the key (transfer = valid & ready)
//     key_pressed debounced "accepted key is held" level
//     overrun     sticky flag: a press was dropped while key_valid was set
//     ovr_clr     synchronous clear of overrun
module keypad_scan #(
    parameter int SCAN_DIV       = 10_000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_pressed,
    output logic       overrun,
    input  logic       ovr_clr
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_TARGET = CW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_PEND   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_PEND = 2'd3
    } state_t;

    logic [3:0]    r_row_meta;
    logic [3:0]    r_row_sync;
    logic [SW-1:0] r_slot;
    logic [1:0]    r_col_idx;
    logic [3:0]    r_col;
    logic [15:0]   r_frame;      // pressed map indexed by {row_idx, col_idx}
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_cand;
    logic [3:0]    r_key_code;
    logic          r_key_valid;
    logic          r_key_pressed;
    logic          r_overrun;

    logic          w_sample;
    logic          w_frame_edge;
    logic [15:0]   w_frame_full;
    logic [4:0]    w_ones;
    logic [3:0]    w_code;
    logic          w_single;
    logic          w_match;
    logic [CW-1:0] w_cnt_inc;
    state_t        w_state_nx;
    logic [CW-1:0] w_cnt_nx;
    logic [3:0]    w_cand_nx;
    logic          w_press;
    logic          w_xfer;
    logic          w_drop;

    assign col         = r_col;
    assign key_code    = r_key_code;
    assign key_valid   = r_key_valid;
    assign key_pressed = r_key_pressed;
    assign overrun     = r_overrun;

    assign w_sample     = (r_slot == SLOT_LAST);
    assign w_frame_edge = w_sample && (r_col_idx == 2'd3);
    assign w_single     = (w_ones == 5'd1);
    assign w_match      = w_single && (w_code == r_cand);
    assign w_cnt_inc    = r_cnt + CW'(1);
    assign w_xfer       = r_key_valid & key_ready;
    // A press is dropped only if the previous key is still unconsumed this edge.
    assign w_drop       = w_press & r_key_valid & ~w_xfer;

    // Two-flop synchroniser for the asynchronous row inputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= row;
            r_row_sync <= r_row_meta;
        end
    end

    // Slot timer, column rotation and per-column capture into the frame map.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_slot    <= {SW{1'b0}};
            r_col_idx <= 2'd0;
            r_col     <= 4'b1110;
            r_frame   <= 16'h0000;
        end else if (w_sample) begin
            r_slot    <= {SW{1'b0}};
            r_col_idx <= r_col_idx + 2'd1;
            r_col     <= {r_col[2:0], r_col[3]};
            for (int r = 0; r < 4; r++) begin
                r_frame[{2'(r), r_col_idx}] <= ~r_row_sync[r];
            end
        end else begin
            r_slot <= r_slot + SW'(1);
        end
    end

    // Full frame seen at the last sample edge: stored columns plus the current one.
    always_comb begin
        w_frame_full = r_frame;
        for (int r = 0; r < 4; r++) begin
            w_frame_full[{2'(r), r_col_idx}] = ~r_row_sync[r];
        end
    end

    // Count pressed positions; w_code is meaningful only when exactly one is set.
    always_comb begin
        w_ones = 5'd0;
        w_code = 4'd0;
        for (int i = 0; i < 16; i++) begin
            w_ones = w_ones + 5'(w_frame_full[i]);
            if (w_frame_full[i]) begin
                w_code = 4'(i);
            end else begin
                w_code = w_code;
            end
        end
    end

    // Debounce next-state logic; advances only on frame-result edges.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_cand_nx  = r_cand;
        w_press    = 1'b0;
        if (w_frame_edge) begin
            case (r_state)
                ST_RELEASED: begin
                    if (w_single) begin
                        w_cand_nx = w_code;
                        if (CNT_TARGET == CW'(1)) begin
                            w_state_nx = ST_PRESSED;
                            w_cnt_nx   = {CW{1'b0}};
                            w_press    = 1'b1;
                        end else begin
                            w_state_nx = ST_PRESS_PEND;
                            w_cnt_nx   = CW'(1);
                        end
                    end else begin
                        w_state_nx = ST_RELEASED;
                        w_cnt_nx   = {CW{1'b0}};
                    end
                end
                ST_PRESS_PEND: begin
                    if (w_match) begin
                        if (w_cnt_inc == CNT_TARGET) begin
                            w_state_nx = ST_PRESSED;
                            w_cnt_nx   = {CW{1'b0}};
                            w_press    = 1'b1;
                        end else begin
                            w_cnt_nx   = w_cnt_inc;
                        end
                    end else begin
                        // A different key or a multi-press abandons the candidate.
                        w_state_nx = ST_RELEASED;
                        w_cnt_nx   = {CW{1'b0}};
                    end
                end
                ST_PRESSED: begin
                    if (w_match) begin
                        w_cnt_nx = {CW{1'b0}};
                    end else if (CNT_TARGET == CW'(1)) begin
                        w_state_nx = ST_RELEASED;
                        w_cnt_nx   = {CW{1'b0}};
                    end else begin
                        w_state_nx = ST_RELEASE_PEND;
                        w_cnt_nx   = CW'(1);
                    end
                end
                ST_RELEASE_PEND: begin
                    if (w_match) begin
                        w_state_nx = ST_PRESSED;
                        w_cnt_nx   = {CW{1'b0}};
                    end else if (w_cnt_inc == CNT_TARGET) begin
                        w_state_nx = ST_RELEASED;
                        w_cnt_nx   = {CW{1'b0}};
                    end else begin
                        w_cnt_nx   = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nx = ST_RELEASED;
                    w_cnt_nx   = {CW{1'b0}};
                end
            endcase
        end else begin
            w_state_nx = r_state;
        end
    end

    // Debounce state, key_pressed level and the handshake output register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state       <= ST_RELEASED;
            r_cnt         <= {CW{1'b0}};
            r_cand        <= 4'd0;
            r_key_pressed <= 1'b0;
            r_key_code    <= 4'd0;
            r_key_valid   <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_cnt         <= w_cnt_nx;
            r_cand        <= w_cand_nx;
            r_key_pressed <= (w_state_nx == ST_PRESSED) || (w_state_nx == ST_RELEASE_PEND);
            if (w_press && !w_drop) begin
                r_key_code  <= w_cand_nx;
                r_key_valid <= 1'b1;
            end else if (w_xfer) begin
                r_key_valid <= 1'b0;
            end else begin
                r_key_valid <= r_key_valid;
            end
            // Setting wins over a simultaneous clear request.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr) begin
                r_overrun <= 1'b0;
            end else begin
                r_overrun <= r_overrun;
            end
        end
    end

endmodule
